// File: rtl/core_run_ctrl_if.sv
// Board-I/O and core-side signals of the run/step/halt sequencer.
interface core_run_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             i_run_sw;
  logic             i_step_key_n;
  logic             i_halt;
  logic             i_insn_vld;
  logic             o_core_en;
  logic [1:0]       o_state;
  logic             o_halted;
  logic [CNT_W-1:0] o_retired;

  // Stimulus side: drives board and core inputs, observes sequencer outputs.
  modport master (
    output i_run_sw, i_step_key_n, i_halt, i_insn_vld,
    input  o_core_en, o_state, o_halted, o_retired
  );

  // Sequencer side.
  modport slave (
    input  i_run_sw, i_step_key_n, i_halt, i_insn_vld,
    output o_core_en, o_state, o_halted, o_retired
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Run/step/halt sequencer: debounces the run switch and step key, drives the
// core clock-enable and counts retired instructions (saturating).
module core_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned STEP_TIMEOUT    = 64,
  parameter int unsigned CNT_W           = 32
) (
  input  logic           i_clk,
  input  logic           i_reset,
  core_run_ctrl_if.slave bus
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMO_W = (STEP_TIMEOUT > 1) ? $clog2(STEP_TIMEOUT) : 1;
  localparam int unsigned RUN_I = 0;
  localparam int unsigned KEY_I = 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_e;

  // Index RUN_I = run switch, KEY_I = step key (active-low, idles high).
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           db_q, db_d;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic                 step_pulse_q;

  state_e               state_q, state_d;
  logic                 core_en_q, core_en_d;
  logic                 halted_q, halted_d;
  logic [TMO_W-1:0]     tmo_q;
  logic [CNT_W-1:0]     retired_q;

  // Two-flop synchronizers on the raw board inputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q <= 2'b10;
      sync2_q <= 2'b10;
    end else begin
      sync1_q <= {bus.i_step_key_n, bus.i_run_sw};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a value is accepted only after DEBOUNCE_CYCLES stable cycles.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i]     = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Debounced state and the one-cycle press pulse (falling edge of the key).
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      db_q         <= 2'b10;
      db_cnt_q     <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      db_q         <= db_d;
      db_cnt_q     <= db_cnt_d;
      step_pulse_q <= db_q[KEY_I] & ~db_d[KEY_I];
    end
  end

  // FSM state register plus registered decodes of the next state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      core_en_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      core_en_q <= core_en_d;
      halted_q  <= halted_d;
    end
  end

  // Next-state logic; halt overrides everything and is only left via reset.
  always_comb begin
    state_d = state_q;
    if (bus.i_halt) begin
      state_d = HALT;
    end else begin
      case (state_q)
        IDLE: begin
          if (db_q[RUN_I])      state_d = RUN;
          else if (step_pulse_q) state_d = STEP;
        end
        RUN: begin
          if (!db_q[RUN_I]) state_d = IDLE;
        end
        STEP: begin
          if (bus.i_insn_vld || (tmo_q == TMO_W'(STEP_TIMEOUT - 1))) state_d = IDLE;
        end
        HALT: state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode of the next state, so the flops mirror the state register.
  always_comb begin
    core_en_d = 1'b0;
    halted_d  = 1'b0;
    if ((state_d == RUN) || (state_d == STEP)) core_en_d = 1'b1;
    if (state_d == HALT)                       halted_d  = 1'b1;
  end

  // Step timeout: zero outside STEP, so each step starts from zero.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)              tmo_q <= '0;
    else if (state_q == STEP)  tmo_q <= tmo_q + TMO_W'(1);
    else                       tmo_q <= '0;
  end

  // Retired-instruction counter: counts commits only while enabled, saturates.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      retired_q <= '0;
    end else if (bus.i_insn_vld && core_en_q && (retired_q != {CNT_W{1'b1}})) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.o_core_en = core_en_q;
  assign bus.o_state   = 2'(state_q);
  assign bus.o_halted  = halted_q;
  assign bus.o_retired = retired_q;

endmodule
